btn_event: RTL and testbench
============================

Name: btn_event

Overview:
- Consumer end of the button path: takes the clean, debounced button level and decodes it into one-cycle event pulses for the clock-setting control logic.
- Events: press, short press (on release), long press, and an optional auto-repeat while the button is held.
- Runs on the 1 kHz system tick, so all time parameters are in milliseconds (clock cycles).
- One instance per debounced button.

Parameters:
- LONG_MS, 1000: cycles of continuous hold (counted from the press pulse) before long_pulse fires. Legal range: at least 2.
- REPEAT_MS, 200: cycles between repeat_pulse events while in long-hold. Legal range: at least 2.
- CNT_W, 11: hold counter width. Must satisfy 2^CNT_W > max(LONG_MS, REPEAT_MS) - 1.

Ports:
- CP_1KHz  input  1  system 1 kHz clock; all logic on the rising edge.
- CR  input  1  reset, synchronous, active-high.
- btn_in  input  1  debounced button level; 1 = pressed; already synchronous to CP_1KHz, no extra synchroniser.
- press_pulse  output  1  one-cycle pulse on the press edge.
- short_pulse  output  1  one-cycle pulse when released before the long threshold.
- long_pulse  output  1  one-cycle pulse when the hold reaches LONG_MS.
- repeat_pulse  output  1  one-cycle pulse every REPEAT_MS while in long-hold.
- held  output  1  high whenever state is not IDLE.

Behaviour:
- Reset: CR=1 at a clock edge gives state=IDLE, cnt=0, and all pulse outputs 0. CR overrides every other condition, including a press in progress.
- Mid-operation reset: no pulse in the cycle after reset. If btn_in is still 1 when CR drops, the next edge is handled as a fresh press from IDLE.
- All outputs are registered. Every pulse is exactly 1 cycle wide; pulse registers default to 0 each cycle unless set below.
- State IDLE:
  - btn_in=1: go to PRESSED, cnt<=0, press_pulse<=1.
  - btn_in=0: stay in IDLE.
- State PRESSED:
  - btn_in=0: go to IDLE, short_pulse<=1.
  - else if cnt==LONG_MS-1: go to LONG, cnt<=0, long_pulse<=1.
  - else: cnt<=cnt+1.
- State LONG:
  - btn_in=0: go to IDLE; no pulse.
  - else if cnt==REPEAT_MS-1: cnt<=0, repeat_pulse<=1 (only when the optional feature is compiled in).
  - else: cnt<=cnt+1.
- Latency:
  - press_pulse is high in the cycle after the first edge that samples btn_in=1.
  - long_pulse is high exactly LONG_MS cycles after press_pulse.
  - The first repeat_pulse is REPEAT_MS cycles after long_pulse, then every REPEAT_MS cycles.
- Simultaneous events:
  - Release sampled on the same edge as the long threshold: release wins, giving short_pulse and no long_pulse.
  - Release coincident with a repeat point: release wins, no repeat_pulse.
- Pulse exclusivity: press_pulse, short_pulse and long_pulse are mutually exclusive in any cycle. A full press/release cycle yields exactly one press_pulse and exactly one of short_pulse or long_pulse.
- Counter width: cnt never exceeds max(LONG_MS, REPEAT_MS) - 1; no wrap-around is possible.
- Minimum gaps:
  - A 1-cycle press (1 on one edge, 0 on the next) gives press_pulse followed immediately by short_pulse on consecutive cycles.
  - A re-press on the edge right after IDLE is re-entered is accepted.
- held: state is registered, so held rises in the same cycle as press_pulse and falls in the cycle after the releasing edge.

Optional Feature:
- Macro: BTN_EVENT_AUTO_REPEAT_EN.
- Defined: LONG state counts and emits repeat_pulse as specified above.
- Undefined:
  - repeat_pulse is tied to constant 0.
  - LONG state holds cnt at 0 and waits only for release.
  - All other behaviour is identical.

Test Plan:
All scenarios use LONG_MS=10, REPEAT_MS=4, with the macro defined unless stated otherwise.
- Reset: CR=1 for 3 cycles with btn_in=1 -> all outputs 0, held=0; after CR drops, press_pulse on the next cycle.
- Short press: btn_in=1 for 5 cycles then 0 -> press_pulse once; short_pulse 5 cycles later; long_pulse and repeat_pulse never; held high for 5 cycles.
- Threshold race: release sampled exactly at the 10th edge after press -> short_pulse=1, long_pulse stays 0.
- Long hold: btn_in=1 for 25 cycles -> long_pulse 10 cycles after press_pulse; repeat_pulse at +4, +8 and +12 after long_pulse; release gives no extra pulse.
- Macro undefined: repeat the 25-cycle hold -> long_pulse at +10, repeat_pulse constantly 0.
- Reset during LONG: CR=1 for 1 cycle at hold cycle 12 -> outputs cleared; next cycle press_pulse again; long_pulse 10 cycles later.

Source files
------------

// File: rtl/btn_event.sv
// btn_event: turns one debounced button level into press / short / long / repeat event pulses.
// Auto-repeat while held is compiled in only when BTN_EVENT_AUTO_REPEAT_EN is defined.
module btn_event #(
   parameter int LONG_MS   = 1000,
   parameter int REPEAT_MS = 200,
   parameter int CNT_W     = 11
) (
   input  logic CP_1KHz,
   input  logic CR,
   input  logic btn_in,
   output logic press_pulse,
   output logic short_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic held
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      LONG    = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_MS - 1);
`ifdef BTN_EVENT_AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_MS - 1);
`endif

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             press_next;
   logic             short_next;
   logic             long_next;
`ifdef BTN_EVENT_AUTO_REPEAT_EN
   logic             repeat_next;
`endif

   // Every output is a register; CR wins over any press in progress.
   always_ff @(posedge CP_1KHz) begin
      if (CR) begin
         state       <= IDLE;
         cnt         <= '0;
         press_pulse <= 1'b0;
         short_pulse <= 1'b0;
         long_pulse  <= 1'b0;
         held        <= 1'b0;
`ifdef BTN_EVENT_AUTO_REPEAT_EN
         repeat_pulse <= 1'b0;
`endif
      end else begin
         state       <= state_next;
         cnt         <= cnt_next;
         press_pulse <= press_next;
         short_pulse <= short_next;
         long_pulse  <= long_next;
         held        <= (state_next != IDLE);
`ifdef BTN_EVENT_AUTO_REPEAT_EN
         repeat_pulse <= repeat_next;
`endif
      end
   end

`ifndef BTN_EVENT_AUTO_REPEAT_EN
   assign repeat_pulse = 1'b0;
`endif

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            cnt_next = '0;
            if (btn_in) begin
               state_next = PRESSED;
            end
         end
         PRESSED: begin
            // Release is checked first so it beats a coincident long threshold.
            if (!btn_in) begin
               state_next = IDLE;
            end else if (cnt == LONG_LAST) begin
               state_next = LONG;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         LONG: begin
            if (!btn_in) begin
               state_next = IDLE;
`ifdef BTN_EVENT_AUTO_REPEAT_EN
            end else if (cnt == REPEAT_LAST) begin
               cnt_next = '0;
            end else begin
               cnt_next = cnt + 1'b1;
            end
`else
            end else begin
               cnt_next = '0;
            end
`endif
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Pulse decode mirrors the transition conditions, so a release always suppresses long/repeat.
   always_comb begin
      press_next = 1'b0;
      short_next = 1'b0;
      long_next  = 1'b0;
`ifdef BTN_EVENT_AUTO_REPEAT_EN
      repeat_next = 1'b0;
`endif
      case (state)
         IDLE:    press_next = btn_in;
         PRESSED: begin
            short_next = !btn_in;
            long_next  = btn_in && (cnt == LONG_LAST);
         end
         LONG: begin
`ifdef BTN_EVENT_AUTO_REPEAT_EN
            repeat_next = btn_in && (cnt == REPEAT_LAST);
`endif
         end
         default: begin
            press_next = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_btn_event.sv
// tb_btn_event: directed stimulus with a hold-age reference model feeding an expected-value queue.
// Expectations adapt to whether BTN_EVENT_AUTO_REPEAT_EN is defined for the build.
module tb_btn_event;

   localparam int LONG_MS   = 10;
   localparam int REPEAT_MS = 4;
   localparam int CNT_W     = 4;
`ifdef BTN_EVENT_AUTO_REPEAT_EN
   localparam bit AUTO_REPEAT = 1'b1;
`else
   localparam bit AUTO_REPEAT = 1'b0;
`endif

   logic CP_1KHz = 1'b0;
   logic CR      = 1'b1;
   logic btn_in  = 1'b0;
   logic press_pulse;
   logic short_pulse;
   logic long_pulse;
   logic repeat_pulse;
   logic held;

   typedef struct packed {
      logic press_ev;
      logic short_ev;
      logic long_ev;
      logic repeat_ev;
      logic held_ev;
   } exp_t;

   exp_t exp_q[$];
   int   compared   = 0;
   int   mismatched = 0;
   bit   m_active   = 1'b0;
   int   m_age      = 0;

   btn_event #(
      .LONG_MS  (LONG_MS),
      .REPEAT_MS(REPEAT_MS),
      .CNT_W    (CNT_W)
   ) dut (
      .CP_1KHz     (CP_1KHz),
      .CR          (CR),
      .btn_in      (btn_in),
      .press_pulse (press_pulse),
      .short_pulse (short_pulse),
      .long_pulse  (long_pulse),
      .repeat_pulse(repeat_pulse),
      .held        (held)
   );

   always #5 CP_1KHz = ~CP_1KHz;

   // Reference model: age counts edges since the press edge; events follow from age alone.
   task automatic model_step(input logic cr_v, input logic btn_v, output exp_t e);
      e = '0;
      if (cr_v) begin
         m_active = 1'b0;
         m_age    = 0;
      end else if (!m_active) begin
         if (btn_v) begin
            m_active   = 1'b1;
            m_age      = 0;
            e.press_ev = 1'b1;
         end
      end else begin
         m_age = m_age + 1;
         if (!btn_v) begin
            m_active   = 1'b0;
            e.short_ev = (m_age <= LONG_MS);
         end else begin
            e.long_ev   = (m_age == LONG_MS);
            e.repeat_ev = AUTO_REPEAT && (m_age > LONG_MS)
                          && (((m_age - LONG_MS) % REPEAT_MS) == 0);
         end
      end
      e.held_ev = m_active;
   endtask

   task automatic compare_bit(input string tag, input logic observed, input logic expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s at %0t: observed=%b expected=%b", tag, $time, observed, expected);
      end
   endtask

   task automatic check_output();
      exp_t e;
      if (exp_q.size() == 0) begin
         compared++;
         mismatched++;
         $error("[TB] FAIL scoreboard_underflow at %0t: observed=empty expected=entry", $time);
      end else begin
         e = exp_q.pop_front();
         compare_bit("press_pulse",  press_pulse,  e.press_ev);
         compare_bit("short_pulse",  short_pulse,  e.short_ev);
         compare_bit("long_pulse",   long_pulse,   e.long_ev);
         compare_bit("repeat_pulse", repeat_pulse, e.repeat_ev);
         compare_bit("held",         held,         e.held_ev);
      end
   endtask

   // Drive n cycles of (cr_v, btn_v) on the falling edge; check just after each rising edge.
   task automatic apply_stimulus(input logic cr_v, input logic btn_v, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         @(negedge CP_1KHz);
         CR     = cr_v;
         btn_in = btn_v;
         model_step(cr_v, btn_v, e);
         exp_q.push_back(e);
         @(posedge CP_1KHz);
         #1;
         check_output();
      end
   endtask

   initial begin
      $display("[TB] btn_event bench, auto-repeat=%0b", AUTO_REPEAT);

      apply_stimulus(1'b1, 1'b1, 3);
      apply_stimulus(1'b0, 1'b1, 2);
      apply_stimulus(1'b0, 1'b0, 3);

      apply_stimulus(1'b0, 1'b1, 5);
      apply_stimulus(1'b0, 1'b0, 3);

      apply_stimulus(1'b0, 1'b1, 10);
      apply_stimulus(1'b0, 1'b0, 3);

      apply_stimulus(1'b0, 1'b1, 11);
      apply_stimulus(1'b0, 1'b0, 2);

      apply_stimulus(1'b0, 1'b1, 25);
      apply_stimulus(1'b0, 1'b0, 3);

      apply_stimulus(1'b0, 1'b1, 1);
      apply_stimulus(1'b0, 1'b0, 1);
      apply_stimulus(1'b0, 1'b1, 1);
      apply_stimulus(1'b0, 1'b0, 2);

      apply_stimulus(1'b0, 1'b1, 12);
      apply_stimulus(1'b1, 1'b1, 1);
      apply_stimulus(1'b0, 1'b1, 16);
      apply_stimulus(1'b0, 1'b0, 2);

      apply_stimulus(1'b0, 1'b1, 14);
      apply_stimulus(1'b1, 1'b0, 1);
      apply_stimulus(1'b0, 1'b0, 2);

      compared++;
      assert (exp_q.size() == 0)
      else begin
         mismatched++;
         $error("[TB] FAIL scoreboard_leftover: observed=%0d expected=0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
